dnn2ami_req_arbiter: RTL and testbench

- Downstream of the write-path sequencer and its sibling read-path sequencer.
- Each path presents one AMI request per cycle on a valid/grant pair. This block arbitrates between the two with bounded-burst round-robin.
- Accepted requests are buffered in a 2-entry output queue that drives the single AMI request port.
- Grants to the paths depend only on registered state, so there is no combinational path from the memory-side grant back to the paths.

---
 rtl/dnn2ami_req_arbiter_pkg.sv | 6 +
 rtl/dnn2ami_skid_q2.sv | 30 +++
 rtl/dnn2ami_req_arbiter.sv | 68 ++++++
 tb/tb_dnn2ami_req_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dnn2ami_req_arbiter_pkg.sv
// dnn2ami_req_arbiter_pkg: shared AMI request width, burst counter width and source ids
package dnn2ami_req_arbiter_pkg;
  localparam int AMI_REQUEST_BUS_WIDTH = 64;
  localparam int BURST_W = 4;
  typedef enum logic {SRC_RD = 1'b0, SRC_WR = 1'b1} src_t;
endpackage

// File: rtl/dnn2ami_skid_q2.sv
// dnn2ami_skid_q2: 2-entry push/pop queue (push/push_data in, pop in, can_accept/count/valid/head out)
module dnn2ami_skid_q2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         can_accept,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;
  assign can_accept = count < 2'd2;
  assign valid = count != 2'd0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && count == 2'd2) head <= tail;
      else if (push && (count == 2'd0 || pop)) head <= push_data;
      if (push && !pop && count == 2'd1) tail <= push_data;
    end
  end
endmodule

// File: rtl/dnn2ami_req_arbiter.sv
// dnn2ami_req_arbiter: bounded-burst round-robin of write/read request paths into one AMI request port
module dnn2ami_req_arbiter
  import dnn2ami_req_arbiter_pkg::*;
#(
  parameter int REQ_W = AMI_REQUEST_BUS_WIDTH,
  parameter int BURST_LEN = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_reqValid,
  input  logic [REQ_W-1:0] wr_reqIn,
  output logic             wr_grant,
  input  logic             rd_reqValid,
  input  logic [REQ_W-1:0] rd_reqIn,
  output logic             rd_grant,
  output logic             mem_reqValid,
  output logic [REQ_W-1:0] mem_reqOut,
  input  logic             mem_reqGrant,
  output logic [CNT_W-1:0] wr_issued_cnt,
  output logic [CNT_W-1:0] rd_issued_cnt,
  output logic             idle
);
  localparam logic [BURST_W-1:0] BL = BURST_W'(BURST_LEN);
  src_t cur_src;
  logic [BURST_W-1:0] burst_cnt;
  logic can_accept, acc, sel_wr, push, pop;
  logic [1:0] q_count;
  src_t g_src;
  // grants look only at registered queue occupancy, and are held off while in reset
  assign acc = can_accept && reset_n;
  // under contention keep cur_src until its burst is used up, then hand over
  always_comb begin
    sel_wr = (wr_reqValid && rd_reqValid) ? ((burst_cnt < BL) == (cur_src == SRC_WR)) : wr_reqValid;
    wr_grant = acc && sel_wr && wr_reqValid;
    rd_grant = acc && !sel_wr && rd_reqValid;
    push = wr_grant || rd_grant;
    g_src = wr_grant ? SRC_WR : SRC_RD;
    pop = mem_reqValid && mem_reqGrant;
    idle = q_count == 2'd0 && !wr_reqValid && !rd_reqValid;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_src <= SRC_RD;
      burst_cnt <= '0;
      wr_issued_cnt <= '0;
      rd_issued_cnt <= '0;
    end else begin
      if (push) begin
        cur_src <= g_src;
        burst_cnt <= (g_src != cur_src) ? BURST_W'(1) : (burst_cnt == BL) ? BL : burst_cnt + BURST_W'(1);
      end
      if (wr_grant) wr_issued_cnt <= wr_issued_cnt + CNT_W'(1);
      if (rd_grant) rd_issued_cnt <= rd_issued_cnt + CNT_W'(1);
    end
  end
  dnn2ami_skid_q2 #(.W(REQ_W)) u_q (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .push_data(wr_grant ? wr_reqIn : rd_reqIn),
    .pop(pop),
    .can_accept(can_accept),
    .count(q_count),
    .valid(mem_reqValid),
    .head(mem_reqOut)
  );
endmodule

// File: tb/tb_dnn2ami_req_arbiter.sv
// tb_dnn2ami_req_arbiter: directed self-checking bench for dnn2ami_req_arbiter
module tb_dnn2ami_req_arbiter;
  localparam int RW = 16;
  logic clk = 0, reset_n = 0;
  logic wr_reqValid = 0, rd_reqValid = 0, mem_reqGrant = 0;
  logic [RW-1:0] wr_reqIn = '0, rd_reqIn = '0;
  logic wr_grant, rd_grant, mem_reqValid, idle;
  logic [RW-1:0] mem_reqOut;
  logic [31:0] wr_cnt, rd_cnt;
  logic wr_grant4, rd_grant4, mem_reqValid4, idle4;
  logic [RW-1:0] mem_reqOut4;
  logic [3:0] wr_cnt4, rd_cnt4;
  int n_chk = 0, n_pass = 0;
  logic [RW-1:0] sb[$];
  always #5 clk = ~clk;
  dnn2ami_req_arbiter #(.REQ_W(RW), .BURST_LEN(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_reqValid(wr_reqValid), .wr_reqIn(wr_reqIn), .wr_grant(wr_grant),
    .rd_reqValid(rd_reqValid), .rd_reqIn(rd_reqIn), .rd_grant(rd_grant),
    .mem_reqValid(mem_reqValid), .mem_reqOut(mem_reqOut), .mem_reqGrant(mem_reqGrant),
    .wr_issued_cnt(wr_cnt), .rd_issued_cnt(rd_cnt), .idle(idle)
  );
  dnn2ami_req_arbiter #(.REQ_W(RW), .BURST_LEN(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .wr_reqValid(wr_reqValid), .wr_reqIn(wr_reqIn), .wr_grant(wr_grant4),
    .rd_reqValid(rd_reqValid), .rd_reqIn(rd_reqIn), .rd_grant(rd_grant4),
    .mem_reqValid(mem_reqValid4), .mem_reqOut(mem_reqOut4), .mem_reqGrant(mem_reqGrant),
    .wr_issued_cnt(wr_cnt4), .rd_issued_cnt(rd_cnt4), .idle(idle4)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask
  // FIFO scoreboard: compare the popped head before recording this cycle's push
  always @(negedge clk) begin
    if (!reset_n) sb.delete();
    else begin
      if (mem_reqValid && mem_reqGrant) begin
        if (sb.size() == 0) chk("sb_underflow", mem_reqOut, 64'hdead);
        else chk("sb_order", mem_reqOut, sb.pop_front());
      end
      if (wr_grant) sb.push_back(wr_reqIn);
      if (rd_grant) sb.push_back(rd_reqIn);
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset_n = 0;
    wr_reqValid = 0;
    rd_reqValid = 0;
    mem_reqGrant = 0;
    repeat (2) nxt();
    reset_n = 1;
  endtask
  task automatic drain;
    wr_reqValid = 0;
    rd_reqValid = 0;
    mem_reqGrant = 1;
    repeat (3) nxt();
    mem_reqGrant = 0;
  endtask
  initial begin
    int k, n;
    reset_n = 0;
    nxt();
    @(negedge clk);
    chk("rst_valid", mem_reqValid, 0);
    chk("rst_out", mem_reqOut, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    nxt();
    reset_n = 1;
    @(negedge clk);
    chk("idle_after_rst", idle, 1);
    chk("idle_valid", mem_reqValid, 0);
    nxt();
    wr_reqValid = 1;
    wr_reqIn = 16'h00A5;
    @(negedge clk);
    chk("a5_grant", wr_grant, 1);
    chk("a5_not_yet", mem_reqValid, 0);
    nxt();
    wr_reqValid = 0;
    @(negedge clk);
    chk("a5_grant_off", wr_grant, 0);
    chk("a5_valid", mem_reqValid, 1);
    chk("a5_out", mem_reqOut, 16'h00A5);
    chk("a5_cnt", wr_cnt, 1);
    chk("a5_busy", idle, 0);
    nxt();
    mem_reqGrant = 1;
    nxt();
    mem_reqGrant = 0;
    @(negedge clk);
    chk("a5_drained", mem_reqValid, 0);
    chk("a5_idle", idle, 1);
    do_reset();
    rd_reqValid = 1;
    wr_reqValid = 1;
    mem_reqGrant = 1;
    for (int i = 0; i < 16; i++) begin
      rd_reqIn = 16'h0100 + 16'(i);
      wr_reqIn = 16'h0200 + 16'(i);
      @(negedge clk);
      chk("burst_grants", {wr_grant, rd_grant}, ((i / 4) % 2 == 1) ? 2'b10 : 2'b01);
      nxt();
    end
    wr_reqValid = 0;
    rd_reqValid = 0;
    @(negedge clk);
    chk("burst_wr_cnt", wr_cnt, 8);
    chk("burst_rd_cnt", rd_cnt, 8);
    drain();
    do_reset();
    wr_reqValid = 1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      wr_reqIn = 16'h0300 + 16'(k);
      @(negedge clk);
      chk("bp_grant", wr_grant, i < 2);
      if (wr_grant) k++;
      nxt();
    end
    mem_reqGrant = 1;
    for (int i = 0; i < 4; i++) begin
      wr_reqIn = 16'h0300 + 16'(k);
      @(negedge clk);
      chk("bp_drain_grant", wr_grant, i != 0);
      chk("bp_drain_out", mem_reqOut, 16'h0300 + 16'(i));
      if (wr_grant) k++;
      nxt();
    end
    drain();
    do_reset();
    mem_reqGrant = 1;
    rd_reqValid = 1;
    for (int i = 0; i < 1000; i++) begin
      rd_reqIn = 16'($urandom);
      @(negedge clk);
      chk("pp_grant", rd_grant, 1);
      nxt();
    end
    rd_reqValid = 0;
    @(negedge clk);
    chk("pp_cnt", rd_cnt, 1000);
    chk("pp_occupied", mem_reqValid, 1);
    drain();
    do_reset();
    rd_reqValid = 1;
    wr_reqValid = 1;
    rd_reqIn = 16'h0400;
    wr_reqIn = 16'h0500;
    nxt();
    nxt();
    chk("full_no_grant", rd_grant | wr_grant, 0);
    chk("full_cnt", rd_cnt, 2);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", mem_reqValid, 0);
    chk("arst_rd_cnt", rd_cnt, 0);
    chk("arst_out", mem_reqOut, 0);
    chk("arst_grants", {wr_grant, rd_grant}, 2'b00);
    nxt();
    reset_n = 1;
    @(negedge clk);
    chk("arst_first_rd", {wr_grant, rd_grant}, 2'b01);
    nxt();
    reset_n = 0;
    rd_reqValid = 0;
    nxt();
    reset_n = 1;
    @(negedge clk);
    chk("arst_first_wr", {wr_grant, rd_grant}, 2'b10);
    drain();
    do_reset();
    mem_reqGrant = 1;
    wr_reqValid = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 17; i++) begin
      wr_reqIn = 16'h0600 + 16'(n);
      @(negedge clk);
      if (wr_grant) n++;
      nxt();
    end
    wr_reqValid = 0;
    @(negedge clk);
    chk("wrap_cnt4", wr_cnt4, 1);
    chk("wrap_cnt32", wr_cnt, 17);
    drain();
    @(negedge clk);
    chk("end_idle", idle, 1);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
